// File: rtl/tpu_seq_ctrl.sv
// Command sequencer for the 8x8 systolic matmul unit: decodes host MMIO
// commands into buffer strobes and runs the fixed-length compute phase.
module tpu_seq_ctrl #(
    parameter int unsigned DIM   = 8,
    parameter int unsigned ADDRW = 16,
    parameter int unsigned DATAW = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     r_w,
    input  logic [ADDRW-1:0]         addr,
    output logic                     wr_a,
    output logic [$clog2(DIM)-1:0]   a_row,
    output logic                     wr_b,
    output logic                     wr_c,
    output logic                     rd_c,
    output logic [$clog2(DIM)-1:0]   c_row,
    output logic                     c_half,
    output logic                     en_a,
    output logic                     en_b,
    output logic                     en_sa,
    output logic                     busy,
    output logic                     done,
    output logic [DATAW-1:0]         stat_rdata,
    output logic                     stat_valid
);

    localparam int unsigned RW       = $clog2(DIM);
    localparam int unsigned CNTW     = $clog2(3 * DIM);
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(3 * DIM - 1);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_COMPUTE = 1'b1;

    localparam logic [3:0] REG_A     = 4'd1;
    localparam logic [3:0] REG_B     = 4'd2;
    localparam logic [3:0] REG_C     = 4'd3;
    localparam logic [3:0] REG_START = 4'd4;
    localparam logic [3:0] REG_STAT  = 4'd5;

    logic [0:0]       state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             stat_valid_q;
    logic [DATAW-1:0] stat_rdata_q;
    logic [DATAW-1:0] stat_word;
    logic [3:0]       region;
    logic             start;
    logic             stat_rd;
    logic             bad;
    logic             unused_addr;

    assign region      = addr[11:8];
    assign a_row       = addr[RW+2:3];
    assign c_row       = addr[RW+3:4];
    assign c_half      = addr[3];
    assign unused_addr = ^addr;

    assign busy       = (state_q == S_COMPUTE);
    assign en_a       = busy;
    assign en_sa      = busy;
    assign en_b       = wr_b | busy;
    assign done       = done_q;
    assign stat_valid = stat_valid_q;
    assign stat_rdata = stat_rdata_q;

    // Status snapshot taken from pre-edge state
    always_comb begin
        stat_word       = '0;
        stat_word[0]    = busy;
        stat_word[1]    = done_q;
        stat_word[2]    = err_q;
        stat_word[15:8] = 8'(cnt_q);
    end

    // Command decode, flag updates and next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        err_d     = err_q;
        cmd_ready = 1'b1;
        wr_a      = 1'b0;
        wr_b      = 1'b0;
        wr_c      = 1'b0;
        rd_c      = 1'b0;
        start     = 1'b0;
        stat_rd   = 1'b0;
        bad       = 1'b0;

        if (state_q == S_COMPUTE) begin
            cmd_ready = (region == REG_STAT);
        end

        if (cmd_valid && cmd_ready) begin
            case (region)
                REG_A:     wr_a = r_w;
                REG_B:     wr_b = r_w;
                REG_C: begin
                    wr_c = r_w;
                    rd_c = ~r_w;
                end
                REG_START: begin
                    if (r_w) start = 1'b1;
                    else     bad   = 1'b1;
                end
                REG_STAT: begin
                    if (!r_w) stat_rd = 1'b1;
                    else      bad     = 1'b1;
                end
                default:   bad = 1'b1;
            endcase
        end

        // Clears first so that same-cycle sets take priority
        if (stat_rd) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        if (bad) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_COMPUTE;
                    cnt_d   = CNT_LOAD;
                    done_d  = 1'b0;
                end
            end
            S_COMPUTE: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            stat_valid_q <= 1'b0;
            stat_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            err_q        <= err_d;
            stat_valid_q <= stat_rd;
            if (stat_rd) begin
                stat_rdata_q <= stat_word;
            end
        end
    end

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Directed self-checking bench for tpu_seq_ctrl: decode, compute timing,
// stalls, status word, error flag and mid-compute reset.
module tb_tpu_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        r_w;
    logic [15:0] addr;
    logic        wr_a, wr_b, wr_c, rd_c, c_half;
    logic [2:0]  a_row, c_row;
    logic        en_a, en_b, en_sa, busy, done;
    logic [63:0] stat_rdata;
    logic        stat_valid;

    int checks;
    int failures;

    tpu_seq_ctrl #(.DIM(8), .ADDRW(16), .DATAW(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .r_w        (r_w),
        .addr       (addr),
        .wr_a       (wr_a),
        .a_row      (a_row),
        .wr_b       (wr_b),
        .wr_c       (wr_c),
        .rd_c       (rd_c),
        .c_row      (c_row),
        .c_half     (c_half),
        .en_a       (en_a),
        .en_b       (en_b),
        .en_sa      (en_sa),
        .busy       (busy),
        .done       (done),
        .stat_rdata (stat_rdata),
        .stat_valid (stat_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
        end
    endtask

    // Inputs change just after a falling edge; the next rising edge consumes them
    task automatic drive(input logic v, input logic rw, input logic [15:0] a);
        cmd_valid = v;
        r_w       = rw;
        addr      = a;
        #1;
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    task automatic stat_read(input string tag, input logic [63:0] exp);
        drive(1'b1, 1'b0, 16'h0500);
        next();
        chk({tag, "_valid"}, 64'(stat_valid), 64'd1);
        chk({tag, "_data"}, stat_rdata, exp);
        drive(1'b0, 1'b0, 16'h0000);
    endtask

    task automatic no_strobes(input string tag);
        chk(tag, 64'({wr_a, wr_b, wr_c, rd_c}), 64'd0);
    endtask

    initial begin
        int n;
        checks    = 0;
        failures  = 0;
        cmd_valid = 1'b0;
        r_w       = 1'b0;
        addr      = '0;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        #1;
        chk("rst_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy_en", 64'({busy, en_a, en_b, en_sa}), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_stat", 64'({stat_valid, stat_rdata}), 64'd0);
        no_strobes("rst_strobes");
        next();
        next();
        rst_n = 1'b1;

        // Write A row 3
        drive(1'b1, 1'b1, 16'h0118);
        chk("wra_strobe", 64'(wr_a), 64'd1);
        chk("wra_row", 64'(a_row), 64'd3);
        chk("wra_ready", 64'(cmd_ready), 64'd1);
        chk("wra_others", 64'({wr_b, wr_c, rd_c, en_b}), 64'd0);
        next();
        drive(1'b0, 1'b0, 16'h0000);
        no_strobes("idle_strobes");

        // Start, then hold a C write that must stall until compute ends
        drive(1'b1, 1'b1, 16'h0400);
        chk("start_ready", 64'(cmd_ready), 64'd1);
        next();
        drive(1'b1, 1'b1, 16'h0300);
        n = 0;
        while (busy && n < 100) begin
            if (cmd_ready || wr_c || !en_a || !en_b || !en_sa || done) begin
                chk("compute_stall", 64'({cmd_ready, wr_c, en_a, en_b, en_sa, done}), 64'b001110);
            end
            n++;
            next();
        end
        chk("compute_len", 64'(n), 64'd24);
        chk("post_done", 64'({busy, done}), 64'b01);
        chk("held_c_accept", 64'({cmd_ready, wr_c, rd_c}), 64'b110);
        chk("held_c_addr", 64'({c_row, c_half}), 64'd0);
        chk("post_en", 64'({en_a, en_sa}), 64'd0);
        next();
        drive(1'b0, 1'b0, 16'h0000);

        // Back-to-back status reads: done then cleared
        drive(1'b1, 1'b0, 16'h0500);
        next();
        chk("st1_valid", 64'(stat_valid), 64'd1);
        chk("st1_data", stat_rdata, 64'h2);
        next();
        chk("st2_valid", 64'(stat_valid), 64'd1);
        chk("st2_data", stat_rdata, 64'h0);
        drive(1'b0, 1'b0, 16'h0000);
        next();
        chk("st_pulse_end", 64'(stat_valid), 64'd0);

        // Second compute with status reads at cnt=10 and on the last cycle
        drive(1'b1, 1'b1, 16'h0400);
        next();
        for (int k = 1; k <= 24; k++) begin
            if (k == 14 || k == 24) begin
                drive(1'b1, 1'b0, 16'h0500);
                if (k == 14) chk("cmp_stat_ready", 64'(cmd_ready), 64'd1);
            end else begin
                drive(1'b0, 1'b0, 16'h0000);
            end
            next();
            if (k == 14) chk("cmp_stat_cnt10", stat_rdata, 64'h0A01);
            if (k == 24) begin
                chk("cmp_stat_last", stat_rdata, 64'h0001);
                chk("last_done_wins", 64'({busy, done}), 64'b01);
            end
        end
        drive(1'b0, 1'b0, 16'h0000);
        stat_read("st_after2", 64'h2);

        // Bad region sets err; status read reports and clears it
        drive(1'b1, 1'b1, 16'h0700);
        chk("err_ready", 64'(cmd_ready), 64'd1);
        no_strobes("err_strobes");
        next();
        drive(1'b0, 1'b0, 16'h0000);
        stat_read("err_read", 64'h4);
        next();
        stat_read("err_cleared", 64'h0);

        // Write to status region sets err again instead of clearing
        drive(1'b1, 1'b1, 16'h0700);
        next();
        drive(1'b1, 1'b1, 16'h0500);
        chk("st_wr_valid_none", 64'(stat_valid), 64'd0);
        next();
        drive(1'b0, 1'b0, 16'h0000);
        chk("st_wr_no_pulse", 64'(stat_valid), 64'd0);
        stat_read("err_held", 64'h4);

        // Start with r_w=0 is an error and must not start compute
        drive(1'b1, 1'b0, 16'h0400);
        next();
        drive(1'b0, 1'b0, 16'h0000);
        chk("bad_start_busy", 64'(busy), 64'd0);
        stat_read("bad_start_err", 64'h4);

        // Reset asserted during compute cycle 12
        drive(1'b1, 1'b1, 16'h0400);
        next();
        drive(1'b0, 1'b0, 16'h0000);
        for (int k = 1; k < 12; k++) next();
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", 64'({busy, en_sa, en_a, en_b, done}), 64'd0);
        chk("mid_rst_ready", 64'(cmd_ready), 64'd1);
        next();
        rst_n = 1'b1;
        next();
        chk("post_rst_ready", 64'(cmd_ready), 64'd1);
        chk("post_rst_done", 64'(done), 64'd0);
        stat_read("post_rst_stat", 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
